// File: rtl/parser_pkg.sv
// Shared parser/deparser definitions: header geometry, tag layout and the
// emitter's FSM state and FIFO entry types.
package parser_pkg;

   localparam int HEAD_WIDTH    = 512;
   localparam int TAG_WIDTH     = 16;
   localparam int TAG_START_BIT = 8;
   localparam int TAG_VALID_BIT = TAG_WIDTH - 1;
   localparam int HLEN_W        = 7;
   localparam int BEAT_WIDTH    = 128;

   typedef enum logic {EMIT_IDLE, EMIT_BUSY} emit_state_t;

   typedef struct packed {
      logic [HEAD_WIDTH-1:0] data;
      logic [HLEN_W-1:0]     len;
   } emit_entry_t;

endpackage

// File: rtl/emit_fifo.sv
// Synchronous header FIFO for the deparser emitter; combinational read of the
// head entry, simultaneous push and pop allowed when full.
module emit_fifo
   import parser_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_push,
   input  emit_entry_t i_entry,
   input  logic        i_pop,
   output emit_entry_t o_entry,
   output logic        o_full,
   output logic        o_empty
);

   localparam int PW = $clog2(DEPTH);

   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [PW:0]   count;
   logic          do_push;
   logic          do_pop;
   emit_entry_t   mem [DEPTH];

   assign o_full  = (count == (PW+1)'(DEPTH));
   assign o_empty = (count == '0);
   assign do_pop  = i_pop && !o_empty;
   assign do_push = i_push && (!o_full || do_pop);
   assign o_entry = mem[rd_ptr];

   // NOTE: the storage array is deliberately not reset; count gates every read, so stale slots are never seen.
   always_ff @(posedge i_clk) begin
      if (do_push) mem[wr_ptr] <= i_entry;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/deparser_emitter.sv
// Serialises rebuilt header words from the deparser into a valid/ready beat
// stream with SOP/EOP/keep, buffering headers against a stalling sink.
module deparser_emitter #(
   parameter int HEAD_WIDTH = parser_pkg::HEAD_WIDTH,
   parameter int TAG_WIDTH  = parser_pkg::TAG_WIDTH,
   parameter int BEAT_WIDTH = parser_pkg::BEAT_WIDTH,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                            i_clk,
   input  logic                            i_rst,
   input  logic [HEAD_WIDTH+TAG_WIDTH-1:0] i_head,
   output logic [BEAT_WIDTH-1:0]           o_data,
   output logic [BEAT_WIDTH/8-1:0]         o_keep,
   output logic                            o_valid,
   output logic                            o_sop,
   output logic                            o_eop,
   input  logic                            i_ready,
   output logic [15:0]                     o_drop_cnt,
   output logic                            o_fifo_empty
);

   import parser_pkg::*;

   localparam int                KW         = BEAT_WIDTH / 8;
   localparam logic [HLEN_W-1:0] MAX_LEN    = HLEN_W'(HEAD_WIDTH / 8);
   localparam logic [HLEN_W-1:0] BEAT_BYTES = HLEN_W'(KW);

   function automatic logic [KW-1:0] eop_keep(input logic [HLEN_W-1:0] n);
      return ~({KW{1'b1}} >> n);
   endfunction

   logic              head_valid;
   logic [HLEN_W-1:0] raw_len;
   logic              tag_unused;
   logic              want_push;
   logic              push;
   logic              drop;
   logic              load;
   logic              accept;
   logic              fifo_full;
   logic              fifo_empty;
   emit_entry_t       push_entry;
   emit_entry_t       pop_entry;

   emit_state_t            state,      state_nxt;
   logic [HEAD_WIDTH-1:0]  sreg,       sreg_nxt;
   logic [HLEN_W-1:0]      beats_left, bl_nxt;
   logic [HLEN_W-1:0]      last_bytes, lb_nxt;
   logic                   valid_nxt,  sop_nxt, eop_nxt;
   logic [KW-1:0]          keep_nxt;

   assign head_valid = i_head[HEAD_WIDTH+TAG_WIDTH-1];
   assign raw_len    = i_head[HEAD_WIDTH +: HLEN_W];
   assign tag_unused = ^i_head[HEAD_WIDTH+TAG_WIDTH-2 : HEAD_WIDTH+HLEN_W];

   // A zero-length word is neither stored nor counted as a drop.
   assign want_push = head_valid && (raw_len != '0);
   assign push      = want_push && (!fifo_full || load);
   assign drop      = want_push && fifo_full && !load;
   assign accept    = o_valid && i_ready;

   always_comb begin
      push_entry.data = i_head[HEAD_WIDTH-1:0];
      push_entry.len  = (raw_len > MAX_LEN) ? MAX_LEN : raw_len;
   end

   emit_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (push),
      .i_entry (push_entry),
      .i_pop   (load),
      .o_entry (pop_entry),
      .o_full  (fifo_full),
      .o_empty (fifo_empty)
   );

   // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch appears.
   always_comb begin
      state_nxt = state;
      sreg_nxt  = sreg;
      bl_nxt    = beats_left;
      lb_nxt    = last_bytes;
      valid_nxt = o_valid;
      sop_nxt   = o_sop;
      eop_nxt   = o_eop;
      keep_nxt  = o_keep;
      load      = 1'b0;

      case (state)
         EMIT_IDLE: load = !fifo_empty;
         EMIT_BUSY: begin
            if (accept) begin
               if (o_eop) begin
                  if (!fifo_empty) begin
                     load = 1'b1;
                  end else begin
                     state_nxt = EMIT_IDLE;
                     valid_nxt = 1'b0;
                     sop_nxt   = 1'b0;
                     eop_nxt   = 1'b0;
                     keep_nxt  = '0;
                  end
               end else begin
                  sreg_nxt = sreg << BEAT_WIDTH;
                  bl_nxt   = beats_left - 1'b1;
                  sop_nxt  = 1'b0;
                  eop_nxt  = (bl_nxt == '0);
                  keep_nxt = (bl_nxt == '0) ? eop_keep(last_bytes) : '1;
               end
            end
         end
         default: state_nxt = EMIT_IDLE;
      endcase

      // Pop straight into the shift register; also covers back-to-back headers.
      if (load) begin
         state_nxt = EMIT_BUSY;
         sreg_nxt  = pop_entry.data;
         bl_nxt    = (pop_entry.len - 1'b1) / BEAT_BYTES;
         lb_nxt    = pop_entry.len - bl_nxt * BEAT_BYTES;
         valid_nxt = 1'b1;
         sop_nxt   = 1'b1;
         eop_nxt   = (bl_nxt == '0);
         keep_nxt  = (bl_nxt == '0) ? eop_keep(lb_nxt) : '1;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state      <= EMIT_IDLE;
         sreg       <= '0;
         beats_left <= '0;
         last_bytes <= '0;
         o_valid    <= 1'b0;
         o_sop      <= 1'b0;
         o_eop      <= 1'b0;
         o_keep     <= '0;
      end else begin
         state      <= state_nxt;
         sreg       <= sreg_nxt;
         beats_left <= bl_nxt;
         last_bytes <= lb_nxt;
         o_valid    <= valid_nxt;
         o_sop      <= sop_nxt;
         o_eop      <= eop_nxt;
         o_keep     <= keep_nxt;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_drop_cnt <= '0;
      end else if (drop && (o_drop_cnt != 16'hFFFF)) begin
         o_drop_cnt <= o_drop_cnt + 1'b1;
      end
   end

   assign o_data       = sreg[HEAD_WIDTH-1 -: BEAT_WIDTH];
   assign o_fifo_empty = fifo_empty;

endmodule

// File: tb/tb_deparser_emitter.sv
// Directed self-checking bench for deparser_emitter: latency, beat framing,
// keep masks, stalls, FIFO overflow drops, length clamp and async reset.
module tb_deparser_emitter;

   logic         i_clk = 1'b0;
   logic         i_rst;
   logic [527:0] i_head;
   logic [127:0] o_data;
   logic [15:0]  o_keep;
   logic         o_valid;
   logic         o_sop;
   logic         o_eop;
   logic         i_ready;
   logic [15:0]  o_drop_cnt;
   logic         o_fifo_empty;

   int errors = 0;
   int checks = 0;

   deparser_emitter dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_head       (i_head),
      .o_data       (o_data),
      .o_keep       (o_keep),
      .o_valid      (o_valid),
      .o_sop        (o_sop),
      .o_eop        (o_eop),
      .i_ready      (i_ready),
      .o_drop_cnt   (o_drop_cnt),
      .o_fifo_empty (o_fifo_empty)
   );

   always #5 i_clk = ~i_clk;

   function automatic logic [511:0] hdr(input logic [7:0] seed);
      logic [511:0] h;
      for (int k = 0; k < 64; k++) h[511-8*k -: 8] = seed + 8'(k);
      return h;
   endfunction

   function automatic logic [527:0] mk(input logic v, input logic [6:0] len, input logic [511:0] d);
      return {v, 8'h00, len, d};
   endfunction

   function automatic logic [127:0] sl(input logic [511:0] d, input int j);
      return d[511-128*j -: 128];
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic beat(input string tag, input logic [511:0] d, input int j,
                       input logic [15:0] k, input logic s, input logic e);
      check({tag, "_valid"}, o_valid, 1'b1);
      check({tag, "_data"},  o_data,  sl(d, j));
      check({tag, "_keep"},  o_keep,  k);
      check({tag, "_sop"},   o_sop,   s);
      check({tag, "_eop"},   o_eop,   e);
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   logic [511:0] h_a, h_b, h_c, h_d, h_e, h_g, h_r, h_s;
   logic [511:0] f [6];

   initial begin
      i_rst   = 1'b1;
      i_head  = '0;
      i_ready = 1'b0;
      h_a = hdr(8'h00);
      h_b = hdr(8'h40);
      h_c = hdr(8'h11);
      h_d = hdr(8'hA0);
      h_e = hdr(8'h55);
      h_g = hdr(8'hC3);
      h_r = hdr(8'h77);
      h_s = hdr(8'h2B);
      for (int k = 0; k < 6; k++) f[k] = hdr(8'(8'h10 * k + 8'h03));

      // Reset values
      repeat (2) @(posedge i_clk);
      #1;
      check("rst_valid", o_valid, 1'b0);
      check("rst_sop",   o_sop,   1'b0);
      check("rst_eop",   o_eop,   1'b0);
      check("rst_data",  o_data,  '0);
      check("rst_keep",  o_keep,  '0);
      check("rst_drop",  o_drop_cnt, 16'd0);
      check("rst_empty", o_fifo_empty, 1'b1);
      i_rst = 1'b0;
      tick();

      // Single 64-byte header, ready high: 4 full beats starting after edge N+1
      i_ready = 1'b1;
      i_head  = mk(1'b1, 7'd64, h_a);
      tick();
      i_head = '0;
      check("t1_lat_valid", o_valid, 1'b0);
      check("t1_lat_empty", o_fifo_empty, 1'b0);
      tick();
      for (int j = 0; j < 4; j++) begin
         beat($sformatf("t1_b%0d", j), h_a, j, 16'hFFFF, j == 0, j == 3);
         tick();
      end
      check("t1_idle_valid", o_valid, 1'b0);
      check("t1_idle_empty", o_fifo_empty, 1'b1);

      // Length 20: two beats, last keeps 4 bytes
      i_head = mk(1'b1, 7'd20, h_b);
      tick();
      i_head = '0;
      tick();
      beat("t2_b0", h_b, 0, 16'hFFFF, 1'b1, 1'b0);
      tick();
      beat("t2_b1", h_b, 1, 16'hF000, 1'b0, 1'b1);
      tick();
      check("t2_idle_valid", o_valid, 1'b0);

      // Lengths 40 then 16 on consecutive cycles: no bubble between headers
      i_head = mk(1'b1, 7'd40, h_c);
      tick();
      i_head = mk(1'b1, 7'd16, h_d);
      tick();
      i_head = '0;
      beat("t3_c0", h_c, 0, 16'hFFFF, 1'b1, 1'b0);
      tick();
      beat("t3_c1", h_c, 1, 16'hFFFF, 1'b0, 1'b0);
      tick();
      beat("t3_c2", h_c, 2, 16'hFF00, 1'b0, 1'b1);
      tick();
      beat("t3_d0", h_d, 0, 16'hFFFF, 1'b1, 1'b1);
      tick();
      check("t3_idle_valid", o_valid, 1'b0);

      // Ready 1,0,0,1 during a 64-byte header: beat 1 held through the stall
      i_head = mk(1'b1, 7'd64, h_e);
      tick();
      i_head = '0;
      tick();
      beat("t4_b0", h_e, 0, 16'hFFFF, 1'b1, 1'b0);
      tick();
      i_ready = 1'b0;
      beat("t4_b1", h_e, 1, 16'hFFFF, 1'b0, 1'b0);
      tick();
      beat("t4_hold1", h_e, 1, 16'hFFFF, 1'b0, 1'b0);
      tick();
      beat("t4_hold2", h_e, 1, 16'hFFFF, 1'b0, 1'b0);
      i_ready = 1'b1;
      tick();
      beat("t4_b2", h_e, 2, 16'hFFFF, 1'b0, 1'b0);
      tick();
      beat("t4_b3", h_e, 3, 16'hFFFF, 1'b0, 1'b1);
      tick();
      check("t4_idle_valid", o_valid, 1'b0);

      // Six headers against a stalled sink: one in output, four stored, one dropped
      i_ready = 1'b0;
      for (int k = 0; k < 6; k++) begin
         i_head = mk(1'b1, 7'd16, f[k]);
         tick();
      end
      check("t5_drop1", o_drop_cnt, 16'd1);
      beat("t5_hold_f0", f[0], 0, 16'hFFFF, 1'b1, 1'b1);
      i_head = mk(1'b1, 7'd0, h_a);
      tick();
      check("t5_len0_nodrop", o_drop_cnt, 16'd1);
      i_head = mk(1'b1, 7'd16, h_b);
      tick();
      check("t5_drop2", o_drop_cnt, 16'd2);
      // Full FIFO: pop and push (length 100, clamped to 64) in the same cycle
      i_head  = mk(1'b1, 7'd100, h_g);
      i_ready = 1'b1;
      beat("t5_f0", f[0], 0, 16'hFFFF, 1'b1, 1'b1);
      tick();
      i_head = '0;
      check("t5_popush_nodrop", o_drop_cnt, 16'd2);
      for (int k = 1; k < 5; k++) begin
         beat($sformatf("t5_f%0d", k), f[k], 0, 16'hFFFF, 1'b1, 1'b1);
         tick();
      end
      for (int j = 0; j < 4; j++) begin
         beat($sformatf("t5_clamp_b%0d", j), h_g, j, 16'hFFFF, j == 0, j == 3);
         tick();
      end
      check("t5_idle_valid", o_valid, 1'b0);
      check("t5_idle_empty", o_fifo_empty, 1'b1);
      check("t5_drop_final", o_drop_cnt, 16'd2);

      // Reset mid-way through beat 2 with another header queued
      i_head = mk(1'b1, 7'd64, h_r);
      tick();
      i_head = mk(1'b1, 7'd16, h_d);
      tick();
      i_head = '0;
      beat("t6_b0", h_r, 0, 16'hFFFF, 1'b1, 1'b0);
      tick();
      beat("t6_b1", h_r, 1, 16'hFFFF, 1'b0, 1'b0);
      tick();
      beat("t6_b2", h_r, 2, 16'hFFFF, 1'b0, 1'b0);
      #2;
      i_rst = 1'b1;
      #1;
      check("t6_rst_valid", o_valid, 1'b0);
      check("t6_rst_eop",   o_eop,   1'b0);
      check("t6_rst_data",  o_data,  '0);
      check("t6_rst_drop",  o_drop_cnt, 16'd0);
      check("t6_rst_empty", o_fifo_empty, 1'b1);
      @(posedge i_clk);
      #1;
      i_rst = 1'b0;
      check("t6_post_valid", o_valid, 1'b0);
      i_head = mk(1'b1, 7'd32, h_s);
      tick();
      i_head = '0;
      tick();
      beat("t6_s0", h_s, 0, 16'hFFFF, 1'b1, 1'b0);
      tick();
      beat("t6_s1", h_s, 1, 16'hFFFF, 1'b0, 1'b1);
      tick();
      check("t6_idle_valid", o_valid, 1'b0);
      check("t6_idle_empty", o_fifo_empty, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
